// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU opcodes, controller states and opcode-class record for alu_ctrl
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    kADD   = 4'h0,
    kR_XOR = 4'h1,
    kXOR   = 4'h2,
    kAND   = 4'h3,
    kRSH   = 4'h4,
    kSEQ   = 4'h5,
    kSLT   = 4'h6,
    kJEQ   = 4'h7,
    kHALT  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    HALT  = 2'd3
  } ctrl_state_t;

  // At most one field is set; all clear means NOP.
  typedef struct packed {
    logic wr_alu;
    logic wr_zero;
    logic wr_sign;
    logic branch;
  } op_class_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational opcode-class decode for alu_ctrl
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  output op_class_t  cls_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      kADD, kR_XOR, kXOR, kAND, kRSH: cls_o.wr_alu  = 1'b1;
      kSEQ:                           cls_o.wr_zero = 1'b1;
      kSLT:                           cls_o.wr_sign = 1'b1;
      kJEQ:                           cls_o.branch  = 1'b1;
      default:                        cls_o         = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - FETCH/EXEC/WB/HALT instruction controller driving an external ALU and register file
// Optional retired-instruction counter enabled by ALU_CTRL_RETIRE_CNT_EN.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter logic [3:0]  HALT_OP = kHALT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InstrValid,
  input  logic [8:0]       Instr,
  output logic             InstrReady,
  output logic [3:0]       AluOp,
  input  logic [7:0]       AluOut,
  input  logic             AluZero,
  output logic [2:0]       RegRdA,
  output logic [2:0]       RegRdB,
  output logic             RegWrEn,
  output logic [7:0]       WrData,
  output logic             BranchTaken,
  output logic             Busy,
`ifdef ALU_CTRL_RETIRE_CNT_EN
  output logic [CNT_W-1:0] RetiredCnt,
`endif
  output logic             Done
);

  ctrl_state_t state_q, state_d;
  logic [8:0]  ir_q, ir_d;
  logic [7:0]  alu_out_q, alu_out_d;
  logic        alu_zero_q, alu_zero_d;
  op_class_t   cls;

  alu_ctrl_dec u_dec (
    .op_i  (ir_q[8:5]),
    .cls_o (cls)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (InstrValid) state_d = (Instr[8:5] == HALT_OP) ? HALT : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ir_d       = ir_q;
    alu_out_d  = alu_out_q;
    alu_zero_d = alu_zero_q;
    if (state_q == FETCH && InstrValid) ir_d = Instr;
    if (state_q == EXEC) begin
      alu_out_d  = AluOut;
      alu_zero_d = AluZero;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ir_q       <= '0;
      alu_out_q  <= '0;
      alu_zero_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      alu_out_q  <= alu_out_d;
      alu_zero_q <= alu_zero_d;
    end
  end

  // Write-side outputs are masked by Reset so a reset landing in WB never commits.
  always_comb begin
    InstrReady  = 1'b0;
    AluOp       = '0;
    RegRdA      = '0;
    RegRdB      = '0;
    RegWrEn     = 1'b0;
    WrData      = '0;
    BranchTaken = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (state_q)
      FETCH: InstrReady = 1'b1;
      EXEC: begin
        AluOp  = ir_q[8:5];
        RegRdA = ir_q[4:2];
        RegRdB = {1'b0, ir_q[1:0]};
        Busy   = 1'b1;
      end
      WB: begin
        RegRdA = ir_q[4:2];
        Busy   = 1'b1;
        if (!Reset) begin
          RegWrEn     = cls.wr_alu | cls.wr_zero | cls.wr_sign;
          BranchTaken = cls.branch & alu_zero_q;
          if (cls.wr_alu)       WrData = alu_out_q;
          else if (cls.wr_zero) WrData = {7'b0, alu_zero_q};
          else if (cls.wr_sign) WrData = {7'b0, alu_out_q[7]};
        end
      end
      HALT:    Done = 1'b1;
      default: InstrReady = 1'b0;
    endcase
  end

`ifdef ALU_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (state_q == WB && retired_q != '1) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign RetiredCnt = retired_q;
`else
  // CNT_W only sizes the optional counter; nothing to build without it.
  if (CNT_W == 0) begin : g_no_cnt
  end
`endif

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter CNT_W, 16, width of optional retired-instruction counter.
REQ-002 Parameter HALT_OP, 4'hF, opcode that halts the controller.
REQ-003 Clk  input  1  single clock, all state on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 InstrValid  input  1  instruction source presents Instr.
REQ-006 Instr  input  9  [8:5] opcode, [4:2] RegA index, [1:0] RegB index.
REQ-007 InstrReady  output  1  controller accepts an instruction this cycle.
REQ-008 AluOp  output  4  opcode driven to ALU OP.
REQ-009 AluOut  input  8  ALU result.
REQ-010 AluZero  input  1  ALU zero flag.
REQ-011 RegRdA  output  3  register-file read address A, also write address.
REQ-012 RegRdB  output  3  register-file read address B, {1'b0, Instr[1:0]}.
REQ-013 RegWrEn  output  1  register write strobe.
REQ-014 WrData  output  8  register write data.
REQ-015 BranchTaken  output  1  one-cycle pulse, JEQ condition true.
REQ-016 Busy  output  1  high in any state other than FETCH and HALT.
REQ-017 Done  output  1  high while halted.

Function
REQ-018 FSM states: FETCH, EXEC, WB, HALT; reset state FETCH.
REQ-019 FETCH: InstrReady=1; on InstrValid&&InstrReady capture Instr into IR, go to EXEC; otherwise stay.
REQ-020 Captured opcode == HALT_OP: go to HALT instead of EXEC.
REQ-021 EXEC (1 cycle): AluOp=IR[8:5], RegRdA=IR[4:2], RegRdB={1'b0,IR[1:0]}; AluOut/AluZero registered at end of cycle; go to WB.
REQ-022 WB (1 cycle): RegRdA held; outputs per opcode class; then FETCH.
REQ-023 kADD, kR_XOR, kXOR, kAND, kRSH: RegWrEn=1, WrData=registered AluOut.
REQ-024 SEQ: RegWrEn=1, WrData={7'b0, registered AluZero}.
REQ-025 SLT: RegWrEn=1, WrData={7'b0, registered AluOut[7]}.
REQ-026 JEQ: RegWrEn=0; BranchTaken=1 iff registered AluZero.
REQ-027 Any other opcode: NOP, RegWrEn=0, BranchTaken=0, still takes EXEC and WB.
REQ-028 Throughput: one instruction per 3 cycles with InstrValid held high; no instruction accepted outside FETCH.
REQ-029 Outside EXEC/WB: AluOp=0, RegRdA=0, RegRdB=0; RegWrEn, BranchTaken, WrData=0 outside WB.
REQ-030 HALT: InstrReady=0, Done=1, Busy=0; exits only via Reset; InstrValid ignored.

Reset
REQ-031 Reset has priority over all transitions; next state FETCH regardless of current state.
REQ-032 Reset clears IR, registered AluOut/AluZero, and all outputs to 0 except InstrReady, which is 1 in the first FETCH cycle after reset.
REQ-033 Reset asserted in WB suppresses the write: RegWrEn and BranchTaken are 0 in the cycle after Reset is sampled.

Configuration
REQ-034 Macro ALU_CTRL_RETIRE_CNT_EN defined: adds output RetiredCnt [CNT_W-1:0], incremented on each WB exit, saturating at all-ones, cleared by Reset.
REQ-035 Macro undefined: no RetiredCnt port, no counter logic; all other behaviour identical.

Structure
REQ-036 The ctrl_state_t enum (FETCH, EXEC, WB, HALT) and kHALT = 4'hF belong in package definitions alongside the existing ALU opcode enum.
REQ-037 Opcode-class decode (write / flag-write / branch / NOP) is one combinational sub-module, alu_ctrl_dec.

Verification
REQ-038 Reset, then Instr={kADD,3'd2,2'd1}, InstrValid=1; AluOut=8'h5A -> EXEC in cycle 2 with AluOp=kADD, RegRdA=2, RegRdB=1; WB in cycle 3 with RegWrEn=1, WrData=8'h5A.
REQ-039 JEQ with AluZero=1 -> BranchTaken=1 for one cycle, RegWrEn=0; repeated with AluZero=0 -> BranchTaken=0.
REQ-040 SLT with AluOut=8'h80 -> WrData=8'h01; SEQ with AluZero=0 -> WrData=8'h00.
REQ-041 Instr opcode 4'hF -> Done=1, InstrReady=0 for 10+ cycles under InstrValid=1; Reset -> FETCH, InstrReady=1, Done=0.
REQ-042 Reset pulsed during WB of kXOR -> no RegWrEn pulse, state FETCH next cycle, all outputs zero except InstrReady.
REQ-043 With ALU_CTRL_RETIRE_CNT_EN and CNT_W=4: 20 back-to-back kAND instructions -> RetiredCnt saturates at 4'hF.
